// File: rtl/grade_calc.sv
// Gradebook accumulator with a sequential restoring divider that produces a
// percentage and one-hot letter lines. Optional macro GRADE_ROUND_EN: round half-up.
module grade_calc #(
  parameter int SCORE_W = 8,
  parameter int SUM_W   = 16,
  parameter int TH_A    = 90,
  parameter int TH_B    = 80,
  parameter int TH_C    = 70,
  parameter int TH_D    = 60
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               score_valid,
  input  logic [SCORE_W-1:0] score_earned,
  input  logic [SCORE_W-1:0] score_max,
  input  logic               compute,
  output logic               busy,
  output logic               grade_valid,
  output logic [6:0]         pct,
  output logic               outA,
  output logic               outB,
  output logic               outC,
  output logic               outD,
  output logic               outF,
  output logic [7:0]         count
);

  localparam int NW = SUM_W + 7;
  localparam int CW = $clog2(NW + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(NW);
  localparam logic [6:0] TH_A7 = 7'(TH_A);
  localparam logic [6:0] TH_B7 = 7'(TH_B);
  localparam logic [6:0] TH_C7 = 7'(TH_C);
  localparam logic [6:0] TH_D7 = 7'(TH_D);

  typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;

  state_t state_q, state_d;

  logic [SUM_W-1:0] sum_earned, sum_max;
  logic [SUM_W-1:0] sum_earned_nx, sum_max_nx;
  logic [SUM_W:0]   rem;
  logic [NW-1:0]    quo;
  logic [SUM_W-1:0] divisor;
  logic [CW-1:0]    bit_cnt;
  logic [4:0]       letters;  // {A, B, C, D, F}

  logic             accept_ok, score_take, comp_take;
  logic [NW-1:0]    x_ext, num;
  logic [SUM_W:0]   rem_sh, rem_nx;
  logic             ge;
  logic [6:0]       pct_nx;
  logic [4:0]       letters_nx;

  function automatic logic [SUM_W-1:0] sat_add(input logic [SUM_W-1:0] a,
                                               input logic [SCORE_W-1:0] b);
    logic [SUM_W:0] s;
    s = {1'b0, a} + {{(SUM_W + 1 - SCORE_W){1'b0}}, b};
    return s[SUM_W] ? '1 : s[SUM_W-1:0];
  endfunction

  assign accept_ok  = !clear && (state_q != DIV);
  assign score_take = accept_ok && score_valid;
  assign comp_take  = accept_ok && compute;

  // A score accepted together with compute is folded into the latched operands.
  assign sum_earned_nx = score_take ? sat_add(sum_earned, score_earned) : sum_earned;
  assign sum_max_nx    = score_take ? sat_add(sum_max, score_max) : sum_max;

  assign x_ext = NW'(sum_earned_nx);
`ifdef GRADE_ROUND_EN
  assign num = (x_ext << 6) + (x_ext << 5) + (x_ext << 2) + NW'(sum_max_nx >> 1);
`else
  assign num = (x_ext << 6) + (x_ext << 5) + (x_ext << 2);
`endif

  // Partial remainder always stays below the divisor, so its top bit is free.
  assign rem_sh = {rem[SUM_W-1:0], quo[NW-1]};
  assign ge     = rem_sh >= {1'b0, divisor};
  assign rem_nx = ge ? (rem_sh - {1'b0, divisor}) : rem_sh;

  always_comb begin
    pct_nx     = '0;
    letters_nx = '0;
    if (divisor != '0) begin
      pct_nx = (|quo[NW-1:7]) ? 7'd127 : quo[6:0];
      if (pct_nx >= TH_A7)      letters_nx = 5'b10000;
      else if (pct_nx >= TH_B7) letters_nx = 5'b01000;
      else if (pct_nx >= TH_C7) letters_nx = 5'b00100;
      else if (pct_nx >= TH_D7) letters_nx = 5'b00010;
      else                      letters_nx = 5'b00001;
    end
  end

  always_comb begin
    // NOTE: default first so every path assigns state_d and no latch is inferred.
    state_d = state_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (clear)           state_d = IDLE;
        else if (comp_take)  state_d = DIV;
        else if (score_take) state_d = IDLE;
      end
      DIV: begin
        if (clear)                   state_d = IDLE;
        else if (bit_cnt == LAST_CNT) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // NOTE: non-blocking assignments throughout so all state updates see pre-edge values.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      sum_earned  <= '0;
      sum_max     <= '0;
      count       <= '0;
      rem         <= '0;
      quo         <= '0;
      divisor     <= '0;
      bit_cnt     <= '0;
      pct         <= '0;
      letters     <= '0;
      grade_valid <= 1'b0;
    end else begin
      if (score_take) begin
        sum_earned  <= sum_earned_nx;
        sum_max     <= sum_max_nx;
        count       <= (count == 8'hFF) ? count : count + 8'd1;
        grade_valid <= 1'b0;
        letters     <= '0;
      end
      if (comp_take) begin
        rem         <= '0;
        quo         <= num;
        divisor     <= sum_max_nx;
        bit_cnt     <= '0;
        grade_valid <= 1'b0;
        letters     <= '0;
      end
      if (state_q == DIV) begin
        if (bit_cnt == LAST_CNT) begin
          pct         <= pct_nx;
          letters     <= letters_nx;
          grade_valid <= 1'b1;
        end else begin
          rem     <= rem_nx;
          quo     <= {quo[NW-2:0], ge};
          bit_cnt <= bit_cnt + CW'(1);
        end
      end
    end
  end

  assign busy = (state_q == DIV);
  assign {outA, outB, outC, outD, outF} = letters;

endmodule

// File: tb/tb_grade_calc.sv
// Directed self-checking bench for grade_calc with hand-computed expectations.
module tb_grade_calc;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       clear = 1'b0;
  logic       score_valid = 1'b0;
  logic [7:0] score_earned = '0;
  logic [7:0] score_max = '0;
  logic       compute = 1'b0;
  logic       busy, grade_valid;
  logic [6:0] pct;
  logic       outA, outB, outC, outD, outF;
  logic [7:0] count;

  int n_checks = 0;
  int n_fail   = 0;

  grade_calc dut (
    .clk(clk), .reset(reset), .clear(clear),
    .score_valid(score_valid), .score_earned(score_earned), .score_max(score_max),
    .compute(compute), .busy(busy), .grade_valid(grade_valid), .pct(pct),
    .outA(outA), .outB(outB), .outC(outC), .outD(outD), .outF(outF), .count(count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [4:0] letters();
    return {outA, outB, outC, outD, outF};
  endfunction

  task automatic add_score(input logic [7:0] e, input logic [7:0] m);
    score_valid = 1'b1; score_earned = e; score_max = m;
    step();
    score_valid = 1'b0; score_earned = '0; score_max = '0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  // Issue compute (optionally with a same-cycle score), wait bounded, check result.
  task automatic run_compute(input string tag, input logic with_score,
                             input logic [7:0] e, input logic [7:0] m,
                             input logic [6:0] exp_pct, input logic [4:0] exp_let);
    int n;
    compute = 1'b1;
    score_valid = with_score; score_earned = e; score_max = m;
    step();
    compute = 1'b0; score_valid = 1'b0; score_earned = '0; score_max = '0;
    check({tag, " busy_start"}, busy, 1);
    check({tag, " gv_busy"}, {letters(), grade_valid}, 0);
    n = 0;
    while (busy && n < 60) begin
      step();
      n++;
    end
    check({tag, " latency"}, n, 24);
    check({tag, " pct"}, pct, exp_pct);
    check({tag, " letters"}, letters(), exp_let);
    check({tag, " grade_valid"}, grade_valid, 1);
  endtask

  initial begin
    // Reset with arbitrary inputs held
    score_valid = 1'b1; compute = 1'b1; clear = 1'b0;
    score_earned = 8'($urandom); score_max = 8'($urandom);
    repeat (3) step();
    check("rst busy", busy, 0);
    check("rst gv", grade_valid, 0);
    check("rst pct", pct, 0);
    check("rst letters", letters(), 0);
    check("rst count", count, 0);
    reset = 1'b0; score_valid = 1'b0; compute = 1'b0;
    score_earned = '0; score_max = '0;
    step();
    check("post rst count", count, 0);

    // 85/100 -> B
    add_score(8'd45, 8'd50);
    add_score(8'd40, 8'd50);
    run_compute("b85", 1'b0, 0, 0, 7'd85, 5'b01000);
    check("b85 count", count, 2);
    repeat (5) step();
    check("hold pct", pct, 85);
    check("hold gv", grade_valid, 1);

    // Empty gradebook -> divisor zero
    do_clear();
    check("clr count", count, 0);
    run_compute("empty", 1'b0, 0, 0, 7'd0, 5'b00000);

    // Extra credit, then a new score invalidates, then recompute
    do_clear();
    add_score(8'd60, 8'd50);
    run_compute("xc120", 1'b0, 0, 0, 7'd120, 5'b10000);
    add_score(8'd0, 8'd100);
    check("inval gv", grade_valid, 0);
    check("inval letters", letters(), 0);
    check("inval count", count, 2);
    run_compute("f40", 1'b0, 0, 0, 7'd40, 5'b00001);

    // Clear mid-division; scores/compute while busy are ignored
    do_clear();
    add_score(8'd10, 8'd20);
    compute = 1'b1;
    step();
    compute = 1'b0;
    repeat (4) step();
    score_valid = 1'b1; score_earned = 8'd5; score_max = 8'd5; compute = 1'b1;
    step();
    score_valid = 1'b0; score_earned = '0; score_max = '0; compute = 1'b0;
    check("busy ignore count", count, 1);
    check("busy still", busy, 1);
    repeat (4) step();
    clear = 1'b1;
    step();
    clear = 1'b0;
    check("midclr busy", busy, 0);
    check("midclr gv", grade_valid, 0);
    check("midclr count", count, 0);
    check("midclr pct", pct, 0);
    run_compute("after clr", 1'b0, 0, 0, 7'd0, 5'b00000);

    // 17900/200 = 89.5
    do_clear();
    add_score(8'd179, 8'd200);
`ifdef GRADE_ROUND_EN
    run_compute("round", 1'b0, 0, 0, 7'd90, 5'b10000);
`else
    run_compute("trunc", 1'b0, 0, 0, 7'd89, 5'b01000);
`endif

    // Percentage saturation: 25500 %
    do_clear();
    add_score(8'd255, 8'd1);
    run_compute("sat127", 1'b0, 0, 0, 7'd127, 5'b10000);

    // Score accepted in the compute cycle: 80/200 -> 40
    do_clear();
    add_score(8'd50, 8'd100);
    run_compute("samecyc", 1'b1, 8'd30, 8'd100, 7'd40, 5'b00001);
    check("samecyc count", count, 2);

    // Sum and count saturation: both sums pin at 65535 -> 100 %
    do_clear();
    for (int i = 0; i < 260; i++) add_score(8'd255, 8'd255);
    check("count sat", count, 255);
    run_compute("sumsat", 1'b0, 0, 0, 7'd100, 5'b10000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
